// File: rtl/cw305_usb_bus_decoder_pkg.sv
// Shared types for the CW305 USB bus decoder: FSM state encoding, read latency
// and saturating-increment helpers used by the optional statistics counters.
package cw305_usb_bus_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ISSUE   = 3'd1,
        ST_RD_CAPTURE = 3'd2,
        ST_RD_HOLD    = 3'd3,
        ST_WR_WAIT    = 3'd4
    } busState_e;

    // Cycles from the rdn pin falling to usb_dout carrying the register byte.
    localparam int unsigned READ_LATENCY = 4;

    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/cw305_usb_bus_decoder_strobe_edge.sv
// One active-low bus strobe: input register, one-cycle delay and edge detect.
// Both stages reset to 1 so that the strobe reads as idle after reset.
module usb_strobe_edge (
    input  logic usb_clk,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic level_q;
    logic delay_q;

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            level_q <= 1'b1;
            delay_q <= 1'b1;
        end else begin
            level_q <= pin_i;
            delay_q <= level_q;
        end
    end

    assign level_o = level_q;
    assign fall_o  = delay_q & ~level_q;
    assign rise_o  = ~delay_q & level_q;

endmodule

// File: rtl/cw305_usb_bus_decoder.sv
// SAM3U external-bus front end for the CW305 register block.
// Define CW305_USB_FE_STATS_EN to add saturating read/write/error counters.
module cw305_usb_bus_decoder
    import cw305_usb_bus_decoder_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic [7:0]                           usb_din,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    input  logic [7:0]                           read_data,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
`ifdef CW305_USB_FE_STATS_EN
    ,
    output logic [15:0]                          stat_rd_cnt,
    output logic [15:0]                          stat_wr_cnt,
    output logic [7:0]                           stat_err_cnt
`endif
);

    busState_e state_q, state_d;

    logic [pADDR_WIDTH-1:0]               addrSync_q;
    logic [7:0]                           dinSync_q;
    logic                                 cenSync_q;
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] regAddress_q;
    logic [pBYTECNT_SIZE-1:0]             regBytecnt_q;
    logic [7:0]                           writeData_q;
    logic [7:0]                           usbDout_q;
    logic                                 usbIsout_q;
    logic                                 regWrite_q;

    logic rdnLevel, rdnFall, rdnRise;
    logic wrnLevel, wrnFall, wrnRise;
    logic bothLow, protoErr, readRelease, writeCommit, writeAbort, latchAddr;

    usb_strobe_edge uRdnEdge (
        .usb_clk (usb_clk),
        .reset_i (reset_i),
        .pin_i   (usb_rdn),
        .level_o (rdnLevel),
        .fall_o  (rdnFall),
        .rise_o  (rdnRise)
    );

    usb_strobe_edge uWrnEdge (
        .usb_clk (usb_clk),
        .reset_i (reset_i),
        .pin_i   (usb_wrn),
        .level_o (wrnLevel),
        .fall_o  (wrnFall),
        .rise_o  (wrnRise)
    );

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            addrSync_q <= '0;
            dinSync_q  <= '0;
            cenSync_q  <= 1'b1;
        end else begin
            addrSync_q <= usb_addr;
            dinSync_q  <= usb_din;
            cenSync_q  <= usb_cen;
        end
    end

    // Overlapping strobes are a host fault; they never start a transaction.
    assign bothLow     = ~rdnLevel & ~wrnLevel;
    assign protoErr    = (state_q == ST_IDLE) & bothLow & (rdnFall | wrnFall);
    assign readRelease = (state_q == ST_RD_HOLD) & (rdnRise | rdnLevel | cenSync_q);
    assign writeCommit = (state_q == ST_WR_WAIT) & wrnRise;
    assign writeAbort  = (state_q == ST_WR_WAIT) & ~wrnRise & cenSync_q;

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bothLow) begin
                    state_d = ST_IDLE;
                end else if (!cenSync_q && rdnFall) begin
                    state_d = ST_RD_ISSUE;
                end else if (!cenSync_q && wrnFall) begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_RD_ISSUE:   state_d = ST_RD_CAPTURE;
            ST_RD_CAPTURE: state_d = ST_RD_HOLD;
            ST_RD_HOLD:    if (readRelease) state_d = ST_IDLE;
            ST_WR_WAIT:    if (writeCommit || writeAbort) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // reg_addrvalid also spans the write-commit cycle, which lands after IDLE is re-entered.
    always_comb begin
        reg_read      = (state_q == ST_RD_ISSUE);
        reg_addrvalid = (state_q != ST_IDLE) | regWrite_q;
        latchAddr     = (state_q == ST_IDLE) & (state_d != ST_IDLE);
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            regAddress_q <= '0;
            regBytecnt_q <= '0;
            writeData_q  <= '0;
            usbDout_q    <= '0;
            usbIsout_q   <= 1'b0;
            regWrite_q   <= 1'b0;
        end else begin
            regWrite_q <= 1'b0;
            if (latchAddr) begin
                regAddress_q <= addrSync_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
                regBytecnt_q <= addrSync_q[pBYTECNT_SIZE-1:0];
            end
            if (state_q == ST_RD_CAPTURE) begin
                usbDout_q  <= read_data;
                usbIsout_q <= 1'b1;
            end
            if (readRelease) begin
                usbIsout_q <= 1'b0;
            end
            if (writeCommit) begin
                writeData_q <= dinSync_q;
                regWrite_q  <= 1'b1;
            end
        end
    end

    assign reg_address = regAddress_q;
    assign reg_bytecnt = regBytecnt_q;
    assign write_data  = writeData_q;
    assign usb_dout    = usbDout_q;
    assign usb_isout   = usbIsout_q;
    assign reg_write   = regWrite_q;

`ifdef CW305_USB_FE_STATS_EN
    logic [15:0] statRdCnt_q;
    logic [15:0] statWrCnt_q;
    logic [7:0]  statErrCnt_q;

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            statRdCnt_q  <= '0;
            statWrCnt_q  <= '0;
            statErrCnt_q <= '0;
        end else begin
            if (readRelease) statRdCnt_q <= satInc16(statRdCnt_q);
            if (writeCommit) statWrCnt_q <= satInc16(statWrCnt_q);
            if (protoErr || writeAbort) statErrCnt_q <= satInc8(statErrCnt_q);
        end
    end

    assign stat_rd_cnt  = statRdCnt_q;
    assign stat_wr_cnt  = statWrCnt_q;
    assign stat_err_cnt = statErrCnt_q;
`endif

endmodule

// File: tb/tb_cw305_usb_bus_decoder.sv
// Directed self-checking bench for cw305_usb_bus_decoder (optionally with CW305_USB_FE_STATS_EN).
module tb_cw305_usb_bus_decoder;

    localparam int AW = 21;
    localparam int BC = 7;

    logic              usb_clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [AW-1:0]     usb_addr = '0;
    logic [7:0]        usb_din = '0;
    logic [7:0]        usb_dout;
    logic              usb_isout;
    logic              usb_rdn = 1'b1;
    logic              usb_wrn = 1'b1;
    logic              usb_cen = 1'b1;
    logic [AW-BC-1:0]  reg_address;
    logic [BC-1:0]     reg_bytecnt;
    logic [7:0]        write_data;
    logic [7:0]        read_data = '0;
    logic              reg_read;
    logic              reg_write;
    logic              reg_addrvalid;
`ifdef CW305_USB_FE_STATS_EN
    logic [15:0]       stat_rd_cnt;
    logic [15:0]       stat_wr_cnt;
    logic [7:0]        stat_err_cnt;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    int readPulses = 0;
    int writePulses = 0;
    logic [7:0] modelByte = '0;

    cw305_usb_bus_decoder #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC)) dut (
        .usb_clk       (usb_clk),
        .reset_i       (reset_i),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_cen       (usb_cen),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .write_data    (write_data),
        .read_data     (read_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid)
`ifdef CW305_USB_FE_STATS_EN
        ,
        .stat_rd_cnt   (stat_rd_cnt),
        .stat_wr_cnt   (stat_wr_cnt),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    always #5 usb_clk = ~usb_clk;

    // Register-block model: read byte appears one cycle after reg_read; strobe pulses are tallied.
    always @(posedge usb_clk) begin
        if (reg_read) begin
            read_data  <= modelByte;
            readPulses <= readPulses + 1;
        end
        if (reg_write) begin
            writePulses <= writePulses + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge usb_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdn, input logic wrn, input logic cen,
                                 input logic [AW-1:0] addr, input logic [7:0] din);
        usb_rdn  = rdn;
        usb_wrn  = wrn;
        usb_cen  = cen;
        usb_addr = addr;
        usb_din  = din;
    endtask

    // Leaves the bus with rdn still low, in cycle 5 of the read (RD_HOLD).
    task automatic startRead(input logic [AW-1:0] addr, input logic [7:0] data,
                             input logic [31:0] expAddr, input logic [31:0] expByte);
        int r0;
        r0 = readPulses;
        modelByte = data;
        applyStimulus(1'b0, 1'b1, 1'b0, addr, 8'h00);
        tick();
        checkOutput("rd_c1_reg_read", 32'(reg_read), 32'd0);
        tick();
        checkOutput("rd_c2_reg_read", 32'(reg_read), 32'd1);
        checkOutput("rd_c2_addrvalid", 32'(reg_addrvalid), 32'd1);
        checkOutput("rd_reg_address", 32'(reg_address), expAddr);
        checkOutput("rd_reg_bytecnt", 32'(reg_bytecnt), expByte);
        tick();
        checkOutput("rd_c3_reg_read", 32'(reg_read), 32'd0);
        checkOutput("rd_c3_isout", 32'(usb_isout), 32'd0);
        tick();
        checkOutput("rd_c4_isout", 32'(usb_isout), 32'd1);
        checkOutput("rd_c4_dout", 32'(usb_dout), 32'(data));
        tick();
        checkOutput("rd_c5_isout", 32'(usb_isout), 32'd1);
        checkOutput("rd_c5_dout", 32'(usb_dout), 32'(data));
        checkOutput("rd_pulse_count", 32'(readPulses - r0), 32'd1);
    endtask

    task automatic releaseRead(input logic [AW-1:0] addr);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 8'h00);
        tick();
        checkOutput("rd_release_c7_isout", 32'(usb_isout), 32'd1);
        tick();
        checkOutput("rd_release_c8_isout", 32'(usb_isout), 32'd0);
        checkOutput("rd_release_c8_addrvalid", 32'(reg_addrvalid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, addr, 8'h00);
        tick(2);
    endtask

    initial begin
        int w0;
        int r0;

        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b1, '0, 8'h00);
        reset_i = 1'b1;
        tick(3);
        checkOutput("rst_isout", 32'(usb_isout), 32'd0);
        checkOutput("rst_dout", 32'(usb_dout), 32'd0);
        checkOutput("rst_reg_read", 32'(reg_read), 32'd0);
        checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
        checkOutput("rst_addrvalid", 32'(reg_addrvalid), 32'd0);
        checkOutput("rst_reg_address", 32'(reg_address), 32'd0);
        checkOutput("rst_write_data", 32'(write_data), 32'd0);
`ifdef CW305_USB_FE_STATS_EN
        checkOutput("rst_stat_wr", 32'(stat_wr_cnt), 32'd0);
`endif
        reset_i = 1'b0;
        tick(2);

        // Write 0xA5 to 0x00105: register 0x02, byte 0x05, commit 2 cycles after wrn rises
        w0 = writePulses;
        applyStimulus(1'b1, 1'b0, 1'b0, 21'h00105, 8'hA5);
        tick(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 21'h00105, 8'hA5);
        tick();
        checkOutput("wr_c4_reg_write", 32'(reg_write), 32'd0);
        checkOutput("wr_c4_addrvalid", 32'(reg_addrvalid), 32'd1);
        tick();
        checkOutput("wr_c5_reg_write", 32'(reg_write), 32'd1);
        checkOutput("wr_write_data", 32'(write_data), 32'hA5);
        checkOutput("wr_reg_address", 32'(reg_address), 32'h02);
        checkOutput("wr_reg_bytecnt", 32'(reg_bytecnt), 32'h05);
        tick();
        checkOutput("wr_c6_reg_write", 32'(reg_write), 32'd0);
        checkOutput("wr_c6_addrvalid", 32'(reg_addrvalid), 32'd0);
        checkOutput("wr_pulse_count", 32'(writePulses - w0), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 21'h00105, 8'hA5);
        tick(2);
`ifdef CW305_USB_FE_STATS_EN
        checkOutput("stat_wr_after_write", 32'(stat_wr_cnt), 32'd1);
`endif

        // Read 0x3C from 0x00283: register 0x05, byte 0x03
        startRead(21'h00283, 8'h3C, 32'h05, 32'h03);
        releaseRead(21'h00283);
`ifdef CW305_USB_FE_STATS_EN
        checkOutput("stat_rd_after_read", 32'(stat_rd_cnt), 32'd1);
`endif

        // Write aborted by cen rising before wrn
        w0 = writePulses;
        applyStimulus(1'b1, 1'b0, 1'b0, 21'h00305, 8'h11);
        tick(3);
        applyStimulus(1'b1, 1'b0, 1'b1, 21'h00305, 8'h11);
        tick();
        checkOutput("abort_c4_addrvalid", 32'(reg_addrvalid), 32'd1);
        tick();
        checkOutput("abort_c5_addrvalid", 32'(reg_addrvalid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 21'h00305, 8'h11);
        tick(4);
        checkOutput("abort_no_write", 32'(writePulses - w0), 32'd0);
        checkOutput("abort_write_data", 32'(write_data), 32'hA5);
`ifdef CW305_USB_FE_STATS_EN
        checkOutput("stat_err_after_abort", 32'(stat_err_cnt), 32'd1);
`endif

        // rdn and wrn fall together: no strobe, bus never driven
        w0 = writePulses;
        r0 = readPulses;
        applyStimulus(1'b0, 1'b0, 1'b0, 21'h00400, 8'h22);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("both_c%0d_isout", i + 1), 32'(usb_isout), 32'd0);
            checkOutput($sformatf("both_c%0d_addrvalid", i + 1), 32'(reg_addrvalid), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 21'h00400, 8'h22);
        tick(3);
        checkOutput("both_no_read", 32'(readPulses - r0), 32'd0);
        checkOutput("both_no_write", 32'(writePulses - w0), 32'd0);
`ifdef CW305_USB_FE_STATS_EN
        checkOutput("stat_err_after_both", 32'(stat_err_cnt), 32'd2);
`endif

        // reset_i while in RD_HOLD, then a clean read
        startRead(21'h00083, 8'h77, 32'h01, 32'h03);
        r0 = readPulses;
        reset_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 21'h00083, 8'h00);
        tick();
        checkOutput("rst_hold_isout", 32'(usb_isout), 32'd0);
        checkOutput("rst_hold_addrvalid", 32'(reg_addrvalid), 32'd0);
        reset_i = 1'b0;
        tick(3);
        checkOutput("rst_hold_no_strobe", 32'(readPulses - r0), 32'd0);
        startRead(21'h00106, 8'h5A, 32'h02, 32'h06);
        releaseRead(21'h00106);
`ifdef CW305_USB_FE_STATS_EN
        checkOutput("stat_rd_after_reset", 32'(stat_rd_cnt), 32'd1);

        // 70000 back-to-back writes saturate the write counter
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        tick(2);
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 21'h00010, 8'h33);
            tick();
            applyStimulus(1'b1, 1'b1, 1'b0, 21'h00010, 8'h33);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 21'h00010, 8'h33);
        tick(4);
        checkOutput("stat_wr_saturated", 32'(stat_wr_cnt), 32'hFFFF);
        checkOutput("stat_rd_untouched", 32'(stat_rd_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
